// File: rtl/id_ex_reg_if.sv
// Signal bundle between the decode stage and the ID/EX pipeline register.
// The decode side takes the master modport and the E-stage register takes the slave modport.
interface id_ex_reg_if;
  logic        StallE;
  logic        FlushE;
  logic        RegWriteD;
  logic        MemtoRegD;
  logic        MemWriteD;
  logic        ALUSrcD;
  logic        RegDstD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] SignImmD;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic [4:0]  RdD;

  logic        RegWriteE;
  logic        MemtoRegE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic        RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] SignImmE;
  logic [4:0]  RsE;
  logic [4:0]  RtE;
  logic [4:0]  RdE;
  logic [4:0]  WriteRegE;
  logic        ValidE;
  logic        WRE_eq_rsD;
  logic        WRE_eq_rtD;
  logic [15:0] BubbleCnt;

  modport master (
    output StallE, FlushE, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
           ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE, ValidE,
           WRE_eq_rsD, WRE_eq_rtD, BubbleCnt
  );

  modport slave (
    input  StallE, FlushE, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
           ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE, ValidE,
           WRE_eq_rsD, WRE_eq_rtD, BubbleCnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: reset > flush (bubble) > stall (hold) > load.
// Define ID_EX_BUBBLE_CNT_EN to build the saturating inserted-bubble counter; otherwise BubbleCnt is 0.
module id_ex_reg (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_reg_if.slave    bus
);

  always_ff @(posedge clk) begin
    if (!rst_n || bus.FlushE) begin
      // A bubble is an all-zero instruction, so it can never write a register or memory.
      bus.RegWriteE   <= 1'b0;
      bus.MemtoRegE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
      bus.ALUSrcE     <= 1'b0;
      bus.RegDstE     <= 1'b0;
      bus.ALUControlE <= 3'd0;
      bus.RD1E        <= 32'd0;
      bus.RD2E        <= 32'd0;
      bus.SignImmE    <= 32'd0;
      bus.RsE         <= 5'd0;
      bus.RtE         <= 5'd0;
      bus.RdE         <= 5'd0;
      bus.ValidE      <= 1'b0;
    end else if (!bus.StallE) begin
      bus.RegWriteE   <= bus.RegWriteD;
      bus.MemtoRegE   <= bus.MemtoRegD;
      bus.MemWriteE   <= bus.MemWriteD;
      bus.ALUSrcE     <= bus.ALUSrcD;
      bus.RegDstE     <= bus.RegDstD;
      bus.ALUControlE <= bus.ALUControlD;
      bus.RD1E        <= bus.RD1D;
      bus.RD2E        <= bus.RD2D;
      bus.SignImmE    <= bus.SignImmD;
      bus.RsE         <= bus.RsD;
      bus.RtE         <= bus.RtD;
      bus.RdE         <= bus.RdD;
      bus.ValidE      <= 1'b1;
    end
  end

  assign bus.WriteRegE = bus.RegDstE ? bus.RdE : bus.RtE;

  // Not gated by RegWriteE; the forwarding/hazard unit ANDs that in itself.
  assign bus.WRE_eq_rsD = (bus.WriteRegE == bus.RsD) && (bus.RsD != 5'd0);
  assign bus.WRE_eq_rtD = (bus.WriteRegE == bus.RtD) && (bus.RtD != 5'd0);

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_reg <= 16'd0;
    end else if (bus.FlushE && (bubble_cnt_reg != 16'hFFFF)) begin
      bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
    end
  end

  assign bus.BubbleCnt = bubble_cnt_reg;
`else
  assign bus.BubbleCnt = 16'd0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: a transaction-level model of the E stage checked every cycle, plus literal anchors.
// Build with +define+ID_EX_BUBBLE_CNT_EN to also exercise the bubble counter and its saturation.
module tb_id_ex_reg;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rw, m2r, mw, asrc, rdst, valid;
    bit [2:0]  alu;
    bit [31:0] rd1, rd2, imm;
    bit [4:0]  rs, rt, rd;
  } e_t;

  e_t          m_e;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the E stage must contain after each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_e   = '{default: 0};
      m_cnt = 0;
    end else if (bus.FlushE) begin
      m_e = '{default: 0};
      if (m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
    end else if (!bus.StallE) begin
      m_e.rw = bus.RegWriteD;   m_e.m2r = bus.MemtoRegD; m_e.mw = bus.MemWriteD;
      m_e.asrc = bus.ALUSrcD;   m_e.rdst = bus.RegDstD;  m_e.alu = bus.ALUControlD;
      m_e.rd1 = bus.RD1D;       m_e.rd2 = bus.RD2D;      m_e.imm = bus.SignImmD;
      m_e.rs = bus.RsD;         m_e.rt = bus.RtD;        m_e.rd = bus.RdD;
      m_e.valid = 1'b1;
    end
    cmp_en = 1'b1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      automatic bit [4:0] wr = m_e.rdst ? m_e.rd : m_e.rt;
      automatic bit [15:0] exp_cnt;
`ifdef ID_EX_BUBBLE_CNT_EN
      exp_cnt = m_cnt[15:0];
`else
      exp_cnt = 16'd0;
`endif
      chk("RegWriteE",   {31'd0, bus.RegWriteE}, {31'd0, m_e.rw});
      chk("MemtoRegE",   {31'd0, bus.MemtoRegE}, {31'd0, m_e.m2r});
      chk("MemWriteE",   {31'd0, bus.MemWriteE}, {31'd0, m_e.mw});
      chk("ALUSrcE",     {31'd0, bus.ALUSrcE},   {31'd0, m_e.asrc});
      chk("RegDstE",     {31'd0, bus.RegDstE},   {31'd0, m_e.rdst});
      chk("ALUControlE", {29'd0, bus.ALUControlE}, {29'd0, m_e.alu});
      chk("RD1E",        bus.RD1E,     m_e.rd1);
      chk("RD2E",        bus.RD2E,     m_e.rd2);
      chk("SignImmE",    bus.SignImmE, m_e.imm);
      chk("RsE",         {27'd0, bus.RsE}, {27'd0, m_e.rs});
      chk("RtE",         {27'd0, bus.RtE}, {27'd0, m_e.rt});
      chk("RdE",         {27'd0, bus.RdE}, {27'd0, m_e.rd});
      chk("WriteRegE",   {27'd0, bus.WriteRegE}, {27'd0, wr});
      chk("ValidE",      {31'd0, bus.ValidE}, {31'd0, m_e.valid});
      chk("WRE_eq_rsD",  {31'd0, bus.WRE_eq_rsD}, {31'd0, (wr == bus.RsD) && (bus.RsD != 0)});
      chk("WRE_eq_rtD",  {31'd0, bus.WRE_eq_rtD}, {31'd0, (wr == bus.RtD) && (bus.RtD != 0)});
      chk("BubbleCnt",   {16'd0, bus.BubbleCnt}, {16'd0, exp_cnt});
    end
  end

  task automatic set_d(input bit rw, input bit rdst, input bit [31:0] rd1,
                       input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
    bus.RegWriteD = rw;  bus.MemtoRegD = rw;  bus.MemWriteD = ~rw; bus.ALUSrcD = rdst;
    bus.RegDstD = rdst;  bus.ALUControlD = rd1[2:0];
    bus.RD1D = rd1;      bus.RD2D = ~rd1;     bus.SignImmD = rd1 ^ 32'h0000FFFF;
    bus.RsD = rs;        bus.RtD = rt;        bus.RdD = rd;
  endtask

  task automatic ctl(input bit stall, input bit flush);
    bus.StallE = stall;
    bus.FlushE = flush;
  endtask

  // Advance one clock; returns 1 ns after the following falling edge.
  task automatic step(input string what);
    @(negedge clk);
    #1;
    $display("txn %-12s stall=%0b flush=%0b valid=%0b wreg=%0d cnt=%0d", what,
             bus.StallE, bus.FlushE, bus.ValidE, bus.WriteRegE, bus.BubbleCnt);
  endtask

  typedef struct { bit stall, flush, rw, rdst; bit [31:0] rd1; bit [4:0] rs, rt, rd; } vec_t;
  vec_t vecs[8] = '{
    '{0, 0, 1, 0, 32'h11111111, 5'd1,  5'd2,  5'd3},
    '{0, 0, 1, 1, 32'h22222222, 5'd3,  5'd2,  5'd9},
    '{0, 1, 1, 1, 32'h33333333, 5'd9,  5'd0,  5'd4},
    '{0, 1, 0, 0, 32'h44444444, 5'd0,  5'd0,  5'd0},
    '{0, 0, 1, 0, 32'h55555555, 5'd31, 5'd31, 5'd7},
    '{1, 0, 0, 1, 32'h66666666, 5'd31, 5'd6,  5'd6},
    '{1, 1, 1, 1, 32'h77777777, 5'd2,  5'd6,  5'd6},
    '{0, 0, 0, 1, 32'h88888888, 5'd6,  5'd6,  5'd6}
  };

  int unsigned cnt_before;

  initial begin
    rst_n = 1'b0;
    ctl(1, 1);
    set_d(1, 1, 32'hCAFEF00D, 5'd3, 5'd4, 5'd5);
    step("reset");
    step("reset");
    chk("rst_ValidE",    {31'd0, bus.ValidE}, 32'd0);
    chk("rst_WriteRegE", {27'd0, bus.WriteRegE}, 32'd0);
    chk("rst_eq_rs",     {31'd0, bus.WRE_eq_rsD}, 32'd0);
    chk("rst_BubbleCnt", {16'd0, bus.BubbleCnt}, 32'd0);

    // Plain load.
    rst_n = 1'b1;
    ctl(0, 0);
    set_d(1, 1, 32'hDEADBEEF, 5'd1, 5'd2, 5'd5);
    step("load");
    chk("ld_RegWriteE", {31'd0, bus.RegWriteE}, 32'd1);
    chk("ld_WriteRegE", {27'd0, bus.WriteRegE}, 32'd5);
    chk("ld_RD1E",      bus.RD1E, 32'hDEADBEEF);
    chk("ld_ValidE",    {31'd0, bus.ValidE}, 32'd1);

    // Destination comparators, then hold that state for three stalled cycles.
    set_d(1, 0, 32'h12345678, 5'd0, 5'd8, 5'd1);
    step("load_rt8");
    ctl(1, 0);
    set_d(0, 1, 32'hFFFFFFFF, 5'd8, 5'd9, 5'd30);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stl_WriteRegE", {27'd0, bus.WriteRegE}, 32'd8);
      chk("stl_RD1E",      bus.RD1E, 32'h12345678);
      chk("stl_eq_rs",     {31'd0, bus.WRE_eq_rsD}, 32'd1);
      chk("stl_eq_rt",     {31'd0, bus.WRE_eq_rtD}, 32'd0);
    end

    // Flush with RegWriteD=1 produces a bubble and counts it.
    cnt_before = bus.BubbleCnt;
    ctl(0, 1);
    set_d(1, 1, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd7);
    step("flush");
    chk("fl_RegWriteE", {31'd0, bus.RegWriteE}, 32'd0);
    chk("fl_MemWriteE", {31'd0, bus.MemWriteE}, 32'd0);
    chk("fl_WriteRegE", {27'd0, bus.WriteRegE}, 32'd0);
    chk("fl_ValidE",    {31'd0, bus.ValidE}, 32'd0);
    chk("fl_eq_rs0",    {31'd0, bus.WRE_eq_rsD}, 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("fl_BubbleCnt", {16'd0, bus.BubbleCnt}, cnt_before + 1);
`else
    chk("fl_BubbleCnt", {16'd0, bus.BubbleCnt}, 32'd0);
`endif

    // Stall and flush together: flush wins.
    ctl(0, 0);
    set_d(1, 1, 32'h0BADF00D, 5'd1, 5'd2, 5'd3);
    step("load");
    ctl(1, 1);
    step("stall_flush");
    chk("sf_ValidE",   {31'd0, bus.ValidE}, 32'd0);
    chk("sf_RD1E",     bus.RD1E, 32'd0);

    // Back-to-back flushes, then a load restores operation immediately.
    ctl(0, 1);
    step("flush");
    step("flush");
    ctl(0, 0);
    set_d(1, 0, 32'h00C0FFEE, 5'd4, 5'd6, 5'd2);
    step("load");
    chk("rl_ValidE",    {31'd0, bus.ValidE}, 32'd1);
    chk("rl_WriteRegE", {27'd0, bus.WriteRegE}, 32'd6);

    // Reset while stalled with loaded state.
    ctl(1, 0);
    rst_n = 1'b0;
    step("reset_stall");
    chk("rs_ValidE",    {31'd0, bus.ValidE}, 32'd0);
    chk("rs_RegWriteE", {31'd0, bus.RegWriteE}, 32'd0);
    chk("rs_BubbleCnt", {16'd0, bus.BubbleCnt}, 32'd0);
    rst_n = 1'b1;

    // Directed vector table; the per-cycle model checks these.
    for (int i = 0; i < 8; i++) begin
      ctl(vecs[i].stall, vecs[i].flush);
      set_d(vecs[i].rw, vecs[i].rdst, vecs[i].rd1, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      step("vector");
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    ctl(0, 1);
    repeat (65537) @(negedge clk);
    #1;
    chk("sat_BubbleCnt", {16'd0, bus.BubbleCnt}, 32'h0000FFFF);
    step("flush_sat");
    chk("sat_hold", {16'd0, bus.BubbleCnt}, 32'h0000FFFF);
`endif

    ctl(0, 0);
    step("idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk rise.
REQ-004 StallE  input  1  hold all E-stage registers (EX multicycle op).
REQ-005 FlushE  input  1  load a bubble (driven from branch/lw stall).
REQ-006 RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  input  1 each  decode controls.
REQ-007 ALUControlD  input  3  ALU op.
REQ-008 RD1D, RD2D, SignImmD  input  32 each  operand data.
REQ-009 RsD, RtD, RdD  input  5 each  register specifiers.
REQ-010 RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE  output  same widths  registered copies.
REQ-011 WriteRegE  output  5  RegDstE ? RdE : RtE (combinational from registers).
REQ-012 ValidE  output  1  E stage holds a real instruction.
REQ-013 WRE_eq_rsD, WRE_eq_rtD  output  1 each  E destination matches current D source.
REQ-014 BubbleCnt  output  16  inserted-bubble count (see Configuration).

Function
REQ-015 Load priority per clk rise SHALL be: reset > FlushE > StallE > load D inputs.
REQ-016 Load: every E register SHALL take its D input; ValidE <= 1; latency exactly one cycle.
REQ-017 Flush (bubble): all control outputs, data outputs and specifiers SHALL become 0; ValidE <= 0.
REQ-018 FlushE with StallE both high SHALL flush (flush wins; no hold).
REQ-019 StallE alone SHALL hold every E register, ValidE and BubbleCnt unchanged.
REQ-020 Bubble SHALL never assert RegWriteE, MemWriteE or MemtoRegE, so downstream hazard and memory logic see no effect.
REQ-021 WRE_eq_rsD SHALL be 1 iff WriteRegE == RsD and RsD != 0; WRE_eq_rtD likewise with RtD; purely combinational, no gating by RegWriteE (consumer ANDs it).
REQ-022 WriteRegE and comparisons SHALL reflect register state of the current cycle, including held state during StallE.
REQ-023 Back-to-back flushes SHALL each produce a bubble; a load following a flush SHALL restore normal operation with no extra cycle.

Reset
REQ-024 On rst_n=0 at clk rise, all outputs registers SHALL clear to 0, ValidE=0, BubbleCnt=0; FlushE/StallE ignored.
REQ-025 Reset mid-stall or mid-flush SHALL clear identically; first cycle after rst_n=1 performs a normal load/flush/stall decision.
REQ-026 Derived outputs after reset: WriteRegE=0, WRE_eq_rsD=WRE_eq_rtD=0.

Configuration
REQ-027 Macro ID_EX_BUBBLE_CNT_EN SHALL control the bubble counter.
REQ-028 Defined: BubbleCnt increments by 1 on each clk rise where FlushE=1 and rst_n=1, saturating at 16'hFFFF (no wrap).
REQ-029 Undefined: no counter register; BubbleCnt port present and tied to 0.

Verification
REQ-030 Load: RegWriteD=1, RegDstD=1, RdD=5, RD1D=32'hDEADBEEF, no stall/flush -> next cycle RegWriteE=1, WriteRegE=5, RD1E=32'hDEADBEEF, ValidE=1.
REQ-031 Flush: E loaded with RegWriteE=1, then FlushE=1 with RegWriteD=1 -> next cycle all controls 0, WriteRegE=0, ValidE=0, BubbleCnt +1 (macro on).
REQ-032 Stall+flush: StallE=1 and FlushE=1 together -> bubble loaded; StallE=1 alone for 3 cycles -> all E outputs constant.
REQ-033 Compare: WriteRegE=8, RsD=8, RtD=9 -> WRE_eq_rsD=1, WRE_eq_rtD=0; WriteRegE=0, RsD=0 -> both 0.
REQ-034 Saturation (macro on): 65537 flush cycles -> BubbleCnt=16'hFFFF; macro off -> BubbleCnt=0 throughout.
REQ-035 Reset mid-stall: StallE=1 with loaded state, rst_n=0 one cycle -> all outputs 0, ValidE=0, BubbleCnt=0.
